// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// Six-digit dynamic-scan driver: a sequential double-dabble converter feeds a display
// buffer, which is blanked, signed and time-multiplexed onto registered sel/seg.
module seg_scan_ctrl #(
  parameter int CNT_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        conv_busy
);

  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        r_state, w_next_state;
  logic [CW-1:0] r_cnt_slot;
  logic [2:0]    r_dig;
  logic          r_init_done;
  logic [19:0]   r_bin;
  logic [23:0]   r_acc;
  logic [4:0]    r_bit;
  logic [5:0]    r_sh_point;
  logic          r_sh_sign;
  logic [23:0]   r_buf_bcd;
  logic [5:0]    r_buf_point;
  logic          r_buf_sign;
  logic          r_buf_vld;
  logic [5:0]    r_sel;
  logic [7:0]    r_seg;

  logic          w_slot_end, w_start;
  logic [19:0]   w_clamped;
  logic [23:0]   w_adj;
  logic [5:0]    w_zero, w_blank, w_minus;
  logic [7:0]    w_code [0:5];
  logic [7:0]    w_cur;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign w_slot_end = (r_cnt_slot == CW'(CNT_MAX));
  // r_init_done is low only during the first clock after reset, giving the boot conversion.
  assign w_start    = !r_init_done || (w_slot_end && r_dig == 3'd5);
  assign w_clamped  = (data > 20'd999_999) ? 20'd999_999 : data;
  assign conv_busy  = (r_state != IDLE);
  assign sel        = r_sel;
  assign seg        = r_seg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_slot  <= '0;
      r_dig       <= 3'd0;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
      if (w_slot_end) begin
        r_cnt_slot <= '0;
        r_dig      <= (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
      end else begin
        r_cnt_slot <= r_cnt_slot + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = SHIFT;
      SHIFT:   if (r_bit == 5'd19) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 6; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bin       <= '0;
      r_acc       <= '0;
      r_bit       <= '0;
      r_sh_point  <= '0;
      r_sh_sign   <= 1'b0;
      r_buf_bcd   <= '0;
      r_buf_point <= '0;
      r_buf_sign  <= 1'b0;
      r_buf_vld   <= 1'b0;
    end else if (r_state == IDLE && w_start) begin
      r_bin      <= w_clamped;
      r_acc      <= '0;
      r_bit      <= '0;
      r_sh_point <= point;
      r_sh_sign  <= sign;
    end else if (r_state == SHIFT) begin
      r_acc <= (w_adj << 1) | {23'd0, r_bin[19]};
      r_bin <= r_bin << 1;
      r_bit <= r_bit + 5'd1;
    end else if (r_state == DONE) begin
      r_buf_bcd   <= r_acc;
      r_buf_point <= r_sh_point;
      r_buf_sign  <= r_sh_sign;
      r_buf_vld   <= 1'b1;
    end
  end

  // Blanking is monotone upward, so the minus sits on the lowest blank digit above a shown one.
  always_comb begin
    logic w_run;
    w_run   = 1'b1;
    w_zero  = '0;
    w_minus = '0;
    for (int k = 5; k >= 0; k--) begin
      w_run     = w_run && (r_buf_bcd[4*k +: 4] == 4'd0) && !r_buf_point[k];
      w_zero[k] = w_run;
    end
    w_blank = w_zero & 6'b111110;
    for (int k = 1; k < 6; k++) begin
      w_minus[k] = r_buf_sign && w_blank[k] && !w_blank[k-1];
    end
    for (int k = 0; k < 6; k++) begin
      if (!r_buf_vld)      w_code[k] = 8'hFF;
      else if (w_blank[k]) w_code[k] = w_minus[k] ? 8'hBF : 8'hFF;
      else                 w_code[k] = seg7(r_buf_bcd[4*k +: 4]) & {~r_buf_point[k], 7'h7F};
    end
  end

  always_comb begin
    case (r_dig)
      3'd0:    w_cur = w_code[0];
      3'd1:    w_cur = w_code[1];
      3'd2:    w_cur = w_code[2];
      3'd3:    w_cur = w_code[3];
      3'd4:    w_cur = w_code[4];
      3'd5:    w_cur = w_code[5];
      default: w_cur = 8'hFF;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sel <= 6'd0;
      r_seg <= 8'hFF;
    end else if (seg_en) begin
      r_sel <= 6'd1 << r_dig;
      r_seg <= w_cur;
    end else begin
      r_sel <= 6'd0;
      r_seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Directed self-checking bench for seg_scan_ctrl with CNT_MAX=24 (25-cycle slots, 150-cycle frames).
module tb_seg_scan_ctrl;

  localparam int SLOT  = 25;
  localparam int FRAME = 150;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [19:0] data = '0;
  logic [5:0]  point = '0;
  logic        sign = 1'b0;
  logic        seg_en = 1'b0;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        conv_busy;

  int vecCount = 0;
  int errCount = 0;
  int cyc = 0;

  seg_scan_ctrl #(.CNT_MAX(24)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .point     (point),
    .sign      (sign),
    .seg_en    (seg_en),
    .sel       (sel),
    .seg       (seg),
    .conv_busy (conv_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(negedge sys_clk);
    cyc++;
  endtask

  task automatic tickTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] d, input logic [5:0] p,
                               input logic s, input logic en);
    data   = d;
    point  = p;
    sign   = s;
    seg_en = en;
  endtask

  function automatic logic [5:0] expSel(input int n);
    return 6'd1 << (((n - 1) / SLOT) % 6);
  endfunction

  // Release reset on a negedge; cyc then counts posedges since release.
  task automatic bootCheck(input string tag, input logic [7:0] dig0Code);
    int firstBusy;
    int busyLen;
    firstBusy = -1;
    busyLen   = 0;
    sys_rst_n = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (conv_busy) begin
        if (firstBusy < 0) firstBusy = cyc;
        busyLen++;
      end
      if (n == 22) begin
        checkOutput({tag, "_blank_sel"}, 32'(sel), 32'h01);
        checkOutput({tag, "_blank_seg"}, 32'(seg), 32'hFF);
      end
      if (n == 23) checkOutput({tag, "_first_seg"}, 32'(seg), 32'(dig0Code));
    end
    checkOutput({tag, "_busy_start"}, 32'(firstBusy), 32'd1);
    checkOutput({tag, "_busy_len"}, 32'(busyLen), 32'd21);
  endtask

  // Moves to the next frame start (which loads the current inputs) and samples each digit late in its slot.
  task automatic checkFrame(input string tag, input logic [47:0] e);
    int base;
    tick();
    while (cyc % FRAME != 0) tick();
    base = cyc;
    for (int k = 0; k < 6; k++) begin
      tickTo(base + SLOT * k + 24);
      checkOutput($sformatf("%s_sel%0d", tag, k), 32'(sel), 32'(6'd1 << k));
      checkOutput($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(e[8*k +: 8]));
    end
  endtask

  initial begin
    logic [47:0] expBasic;
    logic [47:0] expBig;
    int c;
    int k;
    expBasic = 48'hF9_A4_B0_99_92_82;
    expBig   = 48'hF9_C0_C0_C0_C0_C0;

    applyStimulus(20'd123456, 6'b000000, 1'b0, 1'b1);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_sel", 32'(sel), 32'h00);
    checkOutput("rst_seg", 32'(seg), 32'hFF);
    checkOutput("rst_busy", 32'(conv_busy), 32'h0);

    bootCheck("boot", 8'h82);

    for (int n = 151; n <= 300; n++) begin
      tickTo(n);
      k = ((n - 1) / SLOT) % 6;
      checkOutput($sformatf("basic_n%0d", n), 32'({sel, seg}), 32'({expSel(n), expBasic[8*k +: 8]}));
    end

    tickTo(340);
    applyStimulus(20'd42, 6'b000000, 1'b1, 1'b1);
    tickTo(388);
    checkOutput("midframe_hold", 32'({sel, seg}), 32'({6'b001000, 8'hB0}));
    tickTo(471);
    checkOutput("dig0_before_done", 32'({sel, seg}), 32'({6'b000001, 8'h82}));
    tickTo(472);
    checkOutput("dig0_after_done", 32'({sel, seg}), 32'({6'b000001, 8'hA4}));
    checkFrame("sign42", 48'hFF_FF_FF_BF_99_A4);

    applyStimulus(20'd0, 6'b000100, 1'b0, 1'b1);
    checkFrame("point0", 48'hFF_FF_FF_40_C0_C0);

    applyStimulus(20'd5, 6'b001000, 1'b1, 1'b1);
    checkFrame("pointsign", 48'hFF_BF_40_C0_C0_92);

    applyStimulus(20'd0, 6'b000000, 1'b1, 1'b1);
    checkFrame("negzero", 48'hFF_FF_FF_FF_BF_C0);

    applyStimulus(20'hFFFFF, 6'b000000, 1'b1, 1'b1);
    checkFrame("clamp", 48'h90_90_90_90_90_90);

    applyStimulus(20'd100000, 6'b000000, 1'b1, 1'b1);
    checkFrame("signdrop", expBig);

    c = cyc + 7;
    tickTo(c);
    seg_en = 1'b0;
    tick();
    checkOutput("gate_sel", 32'(sel), 32'h00);
    checkOutput("gate_seg", 32'(seg), 32'hFF);
    tickTo(c + 59);
    checkOutput("gate_hold", 32'({sel, seg}), 32'({6'b000000, 8'hFF}));
    tickTo(c + 60);
    seg_en = 1'b1;
    tick();
    k = ((cyc - 1) / SLOT) % 6;
    checkOutput("regate_sel", 32'(sel), 32'(expSel(cyc)));
    checkOutput("regate_seg", 32'(seg), 32'(expBig[8*k +: 8]));

    tick();
    while (cyc % FRAME != 0) tick();
    tickTo(cyc + 10);
    checkOutput("midconv_busy", 32'(conv_busy), 32'h1);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("abort_sel", 32'(sel), 32'h00);
    checkOutput("abort_seg", 32'(seg), 32'hFF);
    checkOutput("abort_busy", 32'(conv_busy), 32'h0);
    applyStimulus(20'd7, 6'b000000, 1'b0, 1'b1);
    repeat (2) @(negedge sys_clk);
    bootCheck("reboot", 8'hF8);
    checkFrame("seven", 48'hFF_FF_FF_FF_FF_F8);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
